// File: rtl/fano_pkg.sv
// Shared constants and types for the PRBS-15 generator/checker pair that sits
// behind fano_decoder.
package fano_pkg;

  localparam int PRBS15_LEN         = 15;
  localparam int PRBS15_TAP_HI      = 14;
  localparam int PRBS15_TAP_LO      = 13;
  localparam int DEFAULT_VERIFY_LEN = 64;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } ber_state_e;

endpackage

// File: rtl/prs_lfsr15.sv
// PRBS-15 (x^15+x^14+1) shift register: load_en shifts in an external bit,
// shift_en free-runs by shifting in its own prediction. Shared with prs_gen.
module prs_lfsr15
  import fano_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load_en,
  input  logic shift_en,
  input  logic i_bit,
  output logic o_pred
);

  logic [PRBS15_LEN-1:0] lfsr_q, lfsr_d;

  assign o_pred = lfsr_q[PRBS15_TAP_HI] ^ lfsr_q[PRBS15_TAP_LO];

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_en) begin
      lfsr_d = {lfsr_q[PRBS15_LEN-2:0], i_bit};
    end else if (shift_en) begin
      lfsr_d = {lfsr_q[PRBS15_LEN-2:0], o_pred};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/prs_ber_checker.sv
// Self-synchronising PRBS-15 BER checker with SEARCH/VERIFY/LOCK alignment.
// Define PRS_BER_TOTAL_EN to add cumulative o_total_bits/o_total_errs outputs.
module prs_ber_checker
  import fano_pkg::*;
#(
  parameter int WIN_W      = 16,
  parameter int CNT_W      = 16,
  parameter int VERIFY_LEN = DEFAULT_VERIFY_LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_vld,
  input  logic             i_sym,
  input  logic             i_sync,
  input  logic [7:0]       i_verify_max,
  input  logic [CNT_W-1:0] i_loss_thr,
  output logic             o_locked,
  output logic             o_stb,
  output logic [CNT_W-1:0] o_err_cnt,
`ifdef PRS_BER_TOTAL_EN
  output logic             o_lock_loss,
  output logic [47:0]      o_total_bits,
  output logic [31:0]      o_total_errs
`else
  output logic             o_lock_loss
`endif
);

  localparam int VC_W = $clog2(VERIFY_LEN + 1);

  ber_state_e       state_q, state_d;
  logic [3:0]       fill_q, fill_d;
  logic [VC_W-1:0]  ver_bits_q, ver_bits_d;
  logic [VC_W-1:0]  ver_errs_q, ver_errs_d;
  logic [WIN_W-1:0] win_bits_q, win_bits_d;
  logic [CNT_W-1:0] win_errs_q, win_errs_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, locked_d;
  logic             stb_q, stb_d;
  logic             loss_q, loss_d;

  logic             load_en, shift_en, pred, bit_err;
  logic [VC_W-1:0]  ver_errs_inc;
  logic [CNT_W-1:0] win_errs_inc;

  // SEARCH fills the LFSR from the line; VERIFY/LOCK let it free-run so that
  // received errors never corrupt the reference sequence.
  assign load_en  = i_sync && i_vld && (state_q == SEARCH);
  assign shift_en = i_sync && i_vld && (state_q != SEARCH);
  assign bit_err  = i_sym ^ pred;

  assign ver_errs_inc = ver_errs_q + VC_W'(bit_err);
  assign win_errs_inc = (win_errs_q == '1) ? win_errs_q : win_errs_q + CNT_W'(bit_err);

  prs_lfsr15 u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .shift_en (shift_en),
    .i_bit    (i_sym),
    .o_pred   (pred)
  );

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    ver_bits_d = ver_bits_q;
    ver_errs_d = ver_errs_q;
    win_bits_d = win_bits_q;
    win_errs_d = win_errs_q;
    err_cnt_d  = err_cnt_q;
    locked_d   = locked_q;
    stb_d      = 1'b0;
    loss_d     = 1'b0;
    // A sync drop overrides everything, including a coincident window end.
    if (!i_sync) begin
      state_d    = SEARCH;
      fill_d     = '0;
      ver_bits_d = '0;
      ver_errs_d = '0;
      win_bits_d = '0;
      win_errs_d = '0;
      locked_d   = 1'b0;
      loss_d     = (state_q == LOCK);
    end else if (i_vld) begin
      unique case (state_q)
        SEARCH: begin
          if (fill_q == 4'(PRBS15_LEN - 1)) begin
            fill_d     = '0;
            ver_bits_d = '0;
            ver_errs_d = '0;
            state_d    = VERIFY;
          end else begin
            fill_d = fill_q + 4'd1;
          end
        end
        VERIFY: begin
          if (ver_bits_q == VC_W'(VERIFY_LEN - 1)) begin
            ver_bits_d = '0;
            ver_errs_d = '0;
            if (32'(ver_errs_inc) <= 32'(i_verify_max)) begin
              state_d    = LOCK;
              locked_d   = 1'b1;
              win_bits_d = '0;
              win_errs_d = '0;
            end else begin
              state_d = SEARCH;
            end
          end else begin
            ver_bits_d = ver_bits_q + VC_W'(1);
            ver_errs_d = ver_errs_inc;
          end
        end
        LOCK: begin
          if (win_bits_q == '1) begin
            err_cnt_d  = win_errs_inc;
            stb_d      = 1'b1;
            win_bits_d = '0;
            win_errs_d = '0;
            if (win_errs_inc > i_loss_thr) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              loss_d   = 1'b1;
            end
          end else begin
            win_bits_d = win_bits_q + WIN_W'(1);
            win_errs_d = win_errs_inc;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SEARCH;
      fill_q     <= '0;
      ver_bits_q <= '0;
      ver_errs_q <= '0;
      win_bits_q <= '0;
      win_errs_q <= '0;
      err_cnt_q  <= '0;
      locked_q   <= 1'b0;
      stb_q      <= 1'b0;
      loss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      ver_bits_q <= ver_bits_d;
      ver_errs_q <= ver_errs_d;
      win_bits_q <= win_bits_d;
      win_errs_q <= win_errs_d;
      err_cnt_q  <= err_cnt_d;
      locked_q   <= locked_d;
      stb_q      <= stb_d;
      loss_q     <= loss_d;
    end
  end

  assign o_locked    = locked_q;
  assign o_stb       = stb_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_lock_loss = loss_q;

`ifdef PRS_BER_TOTAL_EN
  // Totals advance per checked LOCK bit, so abandoned windows still count.
  logic        lock_bit;
  logic [47:0] total_bits_q, total_bits_d;
  logic [31:0] total_errs_q, total_errs_d;

  assign lock_bit = shift_en && (state_q == LOCK);

  always_comb begin
    total_bits_d = total_bits_q;
    total_errs_d = total_errs_q;
    if (lock_bit) begin
      if (total_bits_q != '1) total_bits_d = total_bits_q + 48'd1;
      if (bit_err && (total_errs_q != '1)) total_errs_d = total_errs_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_bits_q <= '0;
      total_errs_q <= '0;
    end else begin
      total_bits_q <= total_bits_d;
      total_errs_q <= total_errs_d;
    end
  end

  assign o_total_bits = total_bits_q;
  assign o_total_errs = total_errs_q;
`endif

endmodule

// File: tb/tb_prs_ber_checker.sv
// Randomised self-checking bench for prs_ber_checker (WIN_W=8, CNT_W=8,
// VERIFY_LEN=64) against a bit-sequence reference model.
module tb_prs_ber_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_vld = 1'b0;
  logic       i_sym = 1'b0;
  logic       i_sync = 1'b1;
  logic [7:0] i_verify_max = 8'd2;
  logic [7:0] i_loss_thr = 8'd20;
  logic       o_locked, o_stb, o_lock_loss;
  logic [7:0] o_err_cnt;
`ifdef PRS_BER_TOTAL_EN
  logic [47:0] o_total_bits;
  logic [31:0] o_total_errs;
`endif

  int vectors = 0;
  int miscompares = 0;

  prs_ber_checker #(.WIN_W(8), .CNT_W(8), .VERIFY_LEN(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_vld        (i_vld),
    .i_sym        (i_sym),
    .i_sync       (i_sync),
    .i_verify_max (i_verify_max),
    .i_loss_thr   (i_loss_thr),
    .o_locked     (o_locked),
    .o_stb        (o_stb),
    .o_err_cnt    (o_err_cnt),
`ifdef PRS_BER_TOTAL_EN
    .o_lock_loss  (o_lock_loss),
    .o_total_bits (o_total_bits),
    .o_total_errs (o_total_errs)
`else
    .o_lock_loss  (o_lock_loss)
`endif
  );

  always #5 clk = ~clk;

  // Transmit-side PRBS-15 source: b[n] = b[n-15] ^ b[n-14].
  bit gen_q[$];

  function automatic bit prbs_next();
    bit b;
    b = gen_q[0] ^ gen_q[1];
    gen_q.push_back(b);
    void'(gen_q.pop_front());
    return b;
  endfunction

  task automatic gen_seed();
    int ones;
    do begin
      gen_q.delete();
      ones = 0;
      for (int i = 0; i < 15; i++) begin
        gen_q.push_back(1'($urandom_range(0, 1)));
        ones += int'(gen_q[i]);
      end
    end while (ones == 0);
  endtask

  // Reference model: mode 0=searching, 1=verifying, 2=locked.
  int     m_mode, m_fill, m_vcnt, m_verr, m_wcnt, m_werr;
  bit     m_hist[$];
  logic   e_locked, e_stb, e_loss;
  logic [7:0] e_cnt;
  longint e_tbits, e_terrs;

  function automatic void model_reset();
    m_mode = 0; m_fill = 0; m_vcnt = 0; m_verr = 0; m_wcnt = 0; m_werr = 0;
    m_hist.delete();
    e_locked = 0; e_stb = 0; e_loss = 0; e_cnt = 0; e_tbits = 0; e_terrs = 0;
  endfunction

  function automatic void model_step(bit vld, bit sym, bit sync);
    bit pred, err;
    e_stb = 0;
    e_loss = 0;
    if (!sync) begin
      if (m_mode == 2) e_loss = 1;
      m_mode = 0; m_fill = 0; m_vcnt = 0; m_verr = 0; m_wcnt = 0; m_werr = 0;
      e_locked = 0;
      return;
    end
    if (!vld) return;
    if (m_mode == 0) begin
      m_hist.push_back(sym);
      if (m_hist.size() > 15) void'(m_hist.pop_front());
      m_fill++;
      if (m_fill == 15) begin
        m_mode = 1; m_fill = 0; m_vcnt = 0; m_verr = 0;
      end
      return;
    end
    pred = m_hist[0] ^ m_hist[1];
    m_hist.push_back(pred);
    void'(m_hist.pop_front());
    err = (sym != pred);
    if (m_mode == 1) begin
      m_vcnt++;
      m_verr += int'(err);
      if (m_vcnt == 64) begin
        if (m_verr <= 2) begin
          m_mode = 2; e_locked = 1; m_wcnt = 0; m_werr = 0;
        end else begin
          m_mode = 0;
        end
        m_vcnt = 0; m_verr = 0;
      end
    end else begin
      m_wcnt++;
      m_werr += int'(err);
      e_tbits++;
      e_terrs += longint'(err);
      if (m_wcnt == 256) begin
        e_stb = 1;
        e_cnt = (m_werr > 255) ? 8'd255 : 8'(m_werr);
        if (e_cnt > 8'd20) begin
          m_mode = 0; e_loss = 1; e_locked = 0;
        end
        m_wcnt = 0; m_werr = 0;
      end
    end
  endfunction

  task automatic drive(input bit vld, input bit sym, input bit sync);
    i_vld = vld;
    i_sym = sym;
    i_sync = sync;
    @(posedge clk);
    #1;
    model_step(vld, sym, sync);
    i_vld = 1'b0;
    i_sync = 1'b1;
  endtask

  task automatic send(input bit flip, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) drive(0, 0, 1);
    drive(1, prbs_next() ^ flip, 1);
  endtask

  task automatic lock_clean(output int n);
    n = 0;
    while (o_locked !== 1'b1 && n < 200) begin
      send(0, 0);
      n++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_vld = 1'b0;
    i_sync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (o_locked !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_locked: got %b expected 0", o_locked); end
    vectors++; if (o_stb !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stb: got %b expected 0", o_stb); end
    vectors++; if (o_lock_loss !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_loss: got %b expected 0", o_lock_loss); end
    vectors++; if (o_err_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", o_err_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_clean_lock();
    int n, nstb;
    gen_seed();
    lock_clean(n);
    vectors++; if (n != 79) begin miscompares++; $display("[TB] FAIL clean_lock_latency: got %0d valids expected 79", n); end
    nstb = 0;
    for (int i = 0; i < 768; i++) begin
      send(0, 0);
      nstb += int'(o_stb === 1'b1);
      vectors++;
      if ({o_locked, o_stb, o_lock_loss, o_err_cnt} !== {e_locked, e_stb, e_loss, e_cnt}) begin
        miscompares++;
        $display("[TB] FAIL clean_stream bit %0d: got %b%b%b/%0d expected %b%b%b/%0d", i,
                 o_locked, o_stb, o_lock_loss, o_err_cnt, e_locked, e_stb, e_loss, e_cnt);
      end
    end
    vectors++; if (nstb != 3) begin miscompares++; $display("[TB] FAIL clean_stb_count: got %0d expected 3", nstb); end
  endtask

  task automatic test_sparse_errors();
    for (int i = 0; i < 768; i++) begin
      send(i % 100 == 99, 1);
      vectors++;
      if ({o_locked, o_stb, o_lock_loss, o_err_cnt} !== {e_locked, e_stb, e_loss, e_cnt}) begin
        miscompares++;
        $display("[TB] FAIL sparse_stream bit %0d: got %b%b%b/%0d expected %b%b%b/%0d", i,
                 o_locked, o_stb, o_lock_loss, o_err_cnt, e_locked, e_stb, e_loss, e_cnt);
      end
      if (o_stb === 1'b1) begin
        vectors++;
        if (o_err_cnt < 8'd2 || o_err_cnt > 8'd3) begin
          miscompares++;
          $display("[TB] FAIL sparse_window_count: got %0d expected 2..3", o_err_cnt);
        end
      end
    end
    vectors++; if (o_locked !== 1'b1) begin miscompares++; $display("[TB] FAIL sparse_keeps_lock: got %b expected 1", o_locked); end
  endtask

  task automatic test_inverted();
    int nlock;
    do_reset();
    gen_seed();
    nlock = 0;
    for (int i = 0; i < 400; i++) begin
      send(1, 1);
      nlock += int'(o_locked !== 1'b0);
      vectors++;
      if ({o_locked, o_stb, o_lock_loss} !== {e_locked, e_stb, e_loss}) begin
        miscompares++;
        $display("[TB] FAIL inverted_stream bit %0d: got %b%b%b expected %b%b%b", i,
                 o_locked, o_stb, o_lock_loss, e_locked, e_stb, e_loss);
      end
    end
    vectors++; if (nlock != 0) begin miscompares++; $display("[TB] FAIL inverted_never_locks: got %0d locked cycles expected 0", nlock); end
  endtask

  task automatic test_error_burst();
    int n, k, p;
    bit flips[256];
    do_reset();
    gen_seed();
    lock_clean(n);
    vectors++; if (n != 79) begin miscompares++; $display("[TB] FAIL burst_lock_latency: got %0d expected 79", n); end
    k = 0;
    while (k < 30) begin
      p = $urandom_range(0, 255);
      if (!flips[p]) begin flips[p] = 1; k++; end
    end
    for (int i = 0; i < 256; i++) begin
      send(flips[i], 1);
      vectors++;
      if ({o_locked, o_stb, o_lock_loss, o_err_cnt} !== {e_locked, e_stb, e_loss, e_cnt}) begin
        miscompares++;
        $display("[TB] FAIL burst_stream bit %0d: got %b%b%b/%0d expected %b%b%b/%0d", i,
                 o_locked, o_stb, o_lock_loss, o_err_cnt, e_locked, e_stb, e_loss, e_cnt);
      end
    end
    vectors++;
    if ({o_locked, o_stb, o_lock_loss, o_err_cnt} !== {1'b0, 1'b1, 1'b1, 8'd30}) begin
      miscompares++;
      $display("[TB] FAIL burst_window_end: got lk=%b stb=%b loss=%b cnt=%0d expected lk=0 stb=1 loss=1 cnt=30",
               o_locked, o_stb, o_lock_loss, o_err_cnt);
    end
    lock_clean(n);
    vectors++; if (n != 79) begin miscompares++; $display("[TB] FAIL burst_relock_latency: got %0d expected 79", n); end
  endtask

  task automatic test_sync_drop();
    int n;
    repeat (100) send(0, 1);
    drive(1, prbs_next(), 0);
    vectors++;
    if ({o_locked, o_stb, o_lock_loss, o_err_cnt} !== {1'b0, 1'b0, 1'b1, 8'd30}) begin
      miscompares++;
      $display("[TB] FAIL sync_drop_lock: got lk=%b stb=%b loss=%b cnt=%0d expected lk=0 stb=0 loss=1 cnt=30",
               o_locked, o_stb, o_lock_loss, o_err_cnt);
    end
    lock_clean(n);
    vectors++; if (n != 79) begin miscompares++; $display("[TB] FAIL sync_relock_latency: got %0d expected 79", n); end
    repeat (255) send(0, 0);
    drive(1, prbs_next(), 0);
    vectors++;
    if ({o_locked, o_stb, o_lock_loss, o_err_cnt} !== {1'b0, 1'b0, 1'b1, 8'd30}) begin
      miscompares++;
      $display("[TB] FAIL sync_drop_window_end: got lk=%b stb=%b loss=%b cnt=%0d expected lk=0 stb=0 loss=1 cnt=30",
               o_locked, o_stb, o_lock_loss, o_err_cnt);
    end
    repeat (45) send(0, 0);
    drive(1, prbs_next(), 0);
    vectors++;
    if ({o_locked, o_stb, o_lock_loss, o_err_cnt} !== {1'b0, 1'b0, 1'b0, 8'd30}) begin
      miscompares++;
      $display("[TB] FAIL sync_drop_verify: got lk=%b stb=%b loss=%b cnt=%0d expected lk=0 stb=0 loss=0 cnt=30",
               o_locked, o_stb, o_lock_loss, o_err_cnt);
    end
    lock_clean(n);
    vectors++; if (n != 79) begin miscompares++; $display("[TB] FAIL sync_verify_relock: got %0d expected 79", n); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 256; i++) begin
      send(i % 50 == 7, 1);
      vectors++;
      if ({o_locked, o_stb, o_lock_loss, o_err_cnt} !== {e_locked, e_stb, e_loss, e_cnt}) begin
        miscompares++;
        $display("[TB] FAIL few_errors_stream bit %0d: got %b%b%b/%0d expected %b%b%b/%0d", i,
                 o_locked, o_stb, o_lock_loss, o_err_cnt, e_locked, e_stb, e_loss, e_cnt);
      end
    end
    vectors++;
    if ({o_locked, o_stb, o_err_cnt} !== {1'b1, 1'b1, 8'd5}) begin
      miscompares++;
      $display("[TB] FAIL few_errors_window: got lk=%b stb=%b cnt=%0d expected lk=1 stb=1 cnt=5", o_locked, o_stb, o_err_cnt);
    end
    repeat (100) send(0, 0);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({o_locked, o_stb, o_lock_loss, o_err_cnt} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_outputs: got lk=%b stb=%b loss=%b cnt=%0d expected all 0",
               o_locked, o_stb, o_lock_loss, o_err_cnt);
    end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_saturation();
    int n;
    lock_clean(n);
    vectors++; if (n != 79) begin miscompares++; $display("[TB] FAIL sat_lock_latency: got %0d expected 79", n); end
    repeat (256) send(1, 1);
    vectors++;
    if ({o_stb, o_lock_loss, o_err_cnt} !== {e_stb, e_loss, e_cnt} || o_err_cnt !== 8'd255 || o_lock_loss !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sat_window: got stb=%b loss=%b cnt=%0d expected stb=1 loss=1 cnt=255", o_stb, o_lock_loss, o_err_cnt);
    end
    lock_clean(n);
    vectors++; if (n != 79) begin miscompares++; $display("[TB] FAIL sat_relock_latency: got %0d expected 79", n); end
    for (int i = 0; i < 256; i++) send(i < 44, 0);
    vectors++;
    if ({o_stb, o_lock_loss, o_err_cnt} !== {1'b1, 1'b1, 8'd44}) begin
      miscompares++;
      $display("[TB] FAIL sat_second_window: got stb=%b loss=%b cnt=%0d expected stb=1 loss=1 cnt=44", o_stb, o_lock_loss, o_err_cnt);
    end
`ifdef PRS_BER_TOTAL_EN
    vectors++;
    if (o_total_errs !== 32'(e_terrs) || o_total_errs !== 32'd300) begin
      miscompares++;
      $display("[TB] FAIL total_errs: got %0d expected 300", o_total_errs);
    end
    vectors++;
    if (o_total_bits !== 48'(e_tbits) || o_total_bits !== 48'd512) begin
      miscompares++;
      $display("[TB] FAIL total_bits: got %0d expected 512", o_total_bits);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_sparse_errors();
    test_inverted();
    test_error_burst();
    test_sync_drop();
    test_async_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
